// File: rtl/spr_dma_ctrl.sv
// Sprite DMA controller.
//
// A CPU write to DMA_REG_ADDR stalls the CPU and copies the 256-byte page
// {page, 8'h00}..{page, 8'hFF} to OAM_DATA_ADDR, one read/write pair per byte.
// While idle, the CPU bus passes straight through to the shared memory bus.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   cpu_addr_i[15:0]     CPU address
//   cpu_wdata_i[7:0]     CPU write data
//   cpu_wen_i, cpu_ren_i CPU write/read strobes
//   cpu_rdata_o[7:0]     read data returned to the CPU (0 while busy)
//   cpu_rdy_o            1 = CPU may advance, 0 = CPU stalled
//   mem_addr_o[15:0]     shared bus address
//   mem_wdata_o[7:0]     shared bus write data
//   mem_wen_o, mem_ren_o shared bus strobes
//   mem_rdata_i[7:0]     shared bus read data (combinational)
//   dma_busy_o           DMA owns the bus
//   dma_done_o           one-cycle pulse in the first idle cycle after a transfer
module spr_dma_ctrl #(
    parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
    parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
    parameter int unsigned ALIGN_CYCLES  = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] cpu_addr_i,
    input  logic [7:0]  cpu_wdata_i,
    input  logic        cpu_wen_i,
    input  logic        cpu_ren_i,
    output logic [7:0]  cpu_rdata_o,
    output logic        cpu_rdy_o,
    output logic [15:0] mem_addr_o,
    output logic [7:0]  mem_wdata_o,
    output logic        mem_wen_o,
    output logic        mem_ren_o,
    input  logic [7:0]  mem_rdata_i,
    output logic        dma_busy_o,
    output logic        dma_done_o
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StAlign = 2'd1;
    localparam logic [1:0] StRead  = 2'd2;
    localparam logic [1:0] StWrite = 2'd3;

    // Counter value on the final align cycle.
    localparam logic [1:0] AlignLast = 2'(ALIGN_CYCLES - 1);

    logic [1:0] state_q, state_d;
    logic [7:0] page_q, page_d;
    logic [7:0] index_q, index_d;
    logic [7:0] data_q, data_d;
    logic [1:0] align_cnt_q, align_cnt_d;
    logic       done_q, done_d;

    logic trigger;
    assign trigger = cpu_wen_i && (cpu_addr_i == DMA_REG_ADDR);

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        index_d     = index_q;
        data_d      = data_q;
        align_cnt_d = align_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (trigger) begin
                    page_d      = cpu_wdata_i;
                    index_d     = 8'h00;
                    align_cnt_d = 2'd0;
                    state_d     = StAlign;
                end
            end
            StAlign: begin
                if (align_cnt_q == AlignLast) begin
                    state_d = StRead;
                end else begin
                    align_cnt_d = align_cnt_q + 2'd1;
                end
            end
            StRead: begin
                data_d  = mem_rdata_i;
                state_d = StWrite;
            end
            StWrite: begin
                index_d = index_q + 8'd1;
                if (index_q == 8'hFF) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    state_d = StRead;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            page_q      <= 8'h00;
            index_q     <= 8'h00;
            data_q      <= 8'h00;
            align_cnt_q <= 2'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            index_q     <= index_d;
            data_q      <= data_d;
            align_cnt_q <= align_cnt_d;
            done_q      <= done_d;
        end
    end

    // Bus ownership: passthrough when idle, DMA-driven otherwise.
    // mem_rdata_i reaches an output only through the idle passthrough.
    always_comb begin
        mem_addr_o  = 16'h0000;
        mem_wdata_o = 8'h00;
        mem_wen_o   = 1'b0;
        mem_ren_o   = 1'b0;
        cpu_rdata_o = 8'h00;
        cpu_rdy_o   = 1'b0;
        dma_busy_o  = 1'b1;
        case (state_q)
            StIdle: begin
                mem_addr_o  = cpu_addr_i;
                mem_wdata_o = cpu_wdata_i;
                mem_wen_o   = cpu_wen_i;
                mem_ren_o   = cpu_ren_i;
                cpu_rdata_o = mem_rdata_i;
                cpu_rdy_o   = 1'b1;
                dma_busy_o  = 1'b0;
            end
            StAlign: begin
            end
            StRead: begin
                mem_addr_o = {page_q, index_q};
                mem_ren_o  = 1'b1;
            end
            StWrite: begin
                mem_addr_o  = OAM_DATA_ADDR;
                mem_wdata_o = data_q;
                mem_wen_o   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign dma_done_o = done_q;

endmodule

// File: doc/spr_dma_ctrl.md
SPR_DMA_CTRL -- requirements
Module: spr_dma_ctrl

Interface
REQ-001 Parameter DMA_REG_ADDR, 16'h4014, CPU write address that triggers a sprite DMA.
REQ-002 Parameter OAM_DATA_ADDR, 16'h2004, destination address written once per byte.
REQ-003 Parameter ALIGN_CYCLES, 1, idle bus cycles between the trigger and the first read (range 1-3).
REQ-004 Port clk  in  1  single clock; all state is updated on its rising edge.
REQ-005 Port rst  in  1  asynchronous, active-low reset.
REQ-006 Port cpu_addr  in  16  CPU address.
REQ-007 Port cpu_wdata  in  8  CPU write data.
REQ-008 Port cpu_wen  in  1  CPU write strobe.
REQ-009 Port cpu_ren  in  1  CPU read strobe.
REQ-010 Port cpu_rdata  out  8  read data returned to the CPU.
REQ-011 Port cpu_rdy  out  1  high = CPU may advance; low = CPU is stalled.
REQ-012 Port mem_addr  out  16  shared bus address.
REQ-013 Port mem_wdata  out  8  shared bus write data.
REQ-014 Port mem_wen  out  1  shared bus write strobe.
REQ-015 Port mem_ren  out  1  shared bus read strobe.
REQ-016 Port mem_rdata  in  8  shared bus read data, combinational in the cycle mem_ren is high.
REQ-017 Port dma_busy  out  1  high while the DMA owns the bus.
REQ-018 Port dma_done  out  1  one-cycle pulse after the last byte is written.

Function
REQ-019 States: IDLE, ALIGN, READ, WRITE.
- IDLE passes the CPU through to the bus.
- ALIGN drives no bus strobes.
- READ and WRITE carry the transfer.
REQ-020 IDLE behaviour:
- mem_addr/mem_wdata/mem_wen/mem_ren equal the CPU inputs.
- cpu_rdata equals mem_rdata.
- cpu_rdy=1 and dma_busy=0.
REQ-021 Trigger: in IDLE with cpu_wen=1 and cpu_addr==DMA_REG_ADDR:
- the write is still forwarded to the bus that cycle;
- page register is loaded with cpu_wdata[7:0];
- 8-bit byte index is cleared;
- next state is ALIGN.
REQ-022 ALIGN behaviour:
- mem_wen=mem_ren=0, mem_addr=0;
- lasts exactly ALIGN_CYCLES cycles, counted by an align counter, then moves to READ.
REQ-023 READ behaviour:
- mem_addr={page,index}, mem_ren=1, mem_wen=0;
- mem_rdata is captured into an 8-bit data register at the clock edge;
- next state is WRITE.
REQ-024 WRITE behaviour:
- mem_addr=OAM_DATA_ADDR, mem_wen=1, mem_ren=0, mem_wdata=data register;
- index increments, wrapping from 8'hFF to 8'h00;
- next state is READ, or IDLE if the index was 8'hFF.
REQ-025 Exactly 256 read/write pairs per trigger, at source addresses {page,8'h00} through {page,8'hFF} in ascending order.
REQ-026 Stall timing:
- cpu_rdy=0 and dma_busy=1 in every ALIGN, READ and WRITE cycle;
- stall length is ALIGN_CYCLES+512 cycles, starting the cycle after the trigger.
REQ-027 cpu_rdata=8'h00 while dma_busy=1.
REQ-028 cpu_wen/cpu_ren are ignored while dma_busy=1, including writes to DMA_REG_ADDR; there is no retrigger or queuing.
REQ-029 dma_done=1 for exactly the first IDLE cycle after the final WRITE; passthrough resumes in that same cycle.
REQ-030 Any page value 8'h00-8'hFF is legal, including IO and ROM pages; the block performs no address filtering.
REQ-031 Back-to-back trigger: a trigger in the dma_done cycle starts a new transfer with normal timing.
REQ-032 No combinational path from mem_rdata to any output other than cpu_rdata in IDLE.

Reset
REQ-033 While rst=0, the block is asynchronously forced to:
- state=IDLE, page=0, index=0, data register=0, align counter=0;
- dma_done=0, dma_busy=0, cpu_rdy=1.
REQ-034 Reset asserted mid-transfer aborts the transfer immediately; no further DMA bus cycles occur after deassertion.
REQ-035 After deassertion, the first rising edge behaves as IDLE.

Verification
REQ-036 Write 8'h02 to 16'h4014 with memory 16'h0200+i = i^8'h5A -> 256 writes to 16'h2004 with data 8'h5A, 8'h5B, ..., 8'hA5 in order; cpu_rdy low for 513 cycles; dma_done pulses once.
REQ-037 Page 8'hFF -> reads at 16'hFF00 through 16'hFFFF; the index wraps and the state returns to IDLE without touching 16'h0000.
REQ-038 CPU writes 16'h4014 again during a transfer -> ignored; exactly 256 writes occur, and the page is unchanged.
REQ-039 rst pulsed low at the 100th WRITE cycle -> cpu_rdy=1, dma_busy=0, mem_wen=0 immediately; no further writes to 16'h2004 occur.
REQ-040 Trigger in the dma_done cycle -> a second 513-cycle stall starts; 512 total writes to 16'h2004 occur.
REQ-041 CPU read of 16'h0005 in IDLE -> mem_ren=1, mem_addr=16'h0005, cpu_rdata=mem_rdata in the same cycle.
